// File: rtl/conv_window_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_window_ctrl_pkg -- shared types/defaults for the 3x3 window sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
package conv_window_ctrl_pkg;

  localparam int DEF_IMAGE_WIDTH  = 512;
  localparam int DEF_IMAGE_HEIGHT = 512;
  localparam int DEF_COL_W        = $clog2(DEF_IMAGE_WIDTH);
  localparam int DEF_ROW_W        = $clog2(DEF_IMAGE_HEIGHT);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} win_state_t;
  typedef enum logic {KSEL_GAUSS, KSEL_SOBEL} kernel_sel_t;

  function automatic logic [1:0] next_lb_sel(input logic [1:0] sel);
    return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_ctrl_raster_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// raster_counter -- column/row raster position, row-mod-3 selector, last flag
// Revision 1.0
// ---------------------------------------------------------------------------
module raster_counter
  import conv_window_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_IMAGE_WIDTH,
  parameter int HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int COL_W  = $clog2(WIDTH),
  parameter int ROW_W  = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             adv_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic [1:0]       sel_o,
  output logic             last_o
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       sel_q, sel_d;
  logic             w_col_end;

  assign w_col_end = (col_q == COL_MAX);
  assign last_o    = w_col_end && (row_q == ROW_MAX);
  assign col_o     = col_q;
  assign row_o     = row_q;
  assign sel_o     = sel_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    sel_d = sel_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
      sel_d = 2'd0;
    end else if (adv_i) begin
      if (w_col_end) begin
        // Wrap back to the frame origin after the last pixel
        col_d = '0;
        row_d = last_o ? '0 : row_q + ROW_W'(1);
        sel_d = last_o ? 2'd0 : next_lb_sel(sel_q);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      sel_q <= 2'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sel_q <= sel_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_window_ctrl -- line-buffer/window sequencer for the 3x3 convolution
// Revision 1.0
// ---------------------------------------------------------------------------
module conv_window_ctrl
  import conv_window_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int COL_W        = $clog2(IMAGE_WIDTH),
  parameter int ROW_W        = $clog2(IMAGE_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             lb_wr_en_o,
  output logic [COL_W-1:0] lb_addr_o,
  output logic [1:0]       lb_wr_sel_o,
  output logic             win_shift_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ROW_W-1:0] out_row_o,
  output logic [COL_W-1:0] out_col_o,
  output logic             kernel_sel_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  win_state_t       state_q, state_d;
  kernel_sel_t      ksel_q, ksel_d;
  logic             out_valid_q, out_valid_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [COL_W-1:0] addr_q, addr_d;
  logic             frame_done_q, frame_done_d;

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [1:0]       w_sel;
  logic             w_last;
  logic             w_accept;
  logic             w_clear;
  logic             w_emit;
  logic             w_handoff;

  raster_counter #(
    .WIDTH  (IMAGE_WIDTH),
    .HEIGHT (IMAGE_HEIGHT),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (w_clear),
    .adv_i   (w_accept),
    .col_o   (w_col),
    .row_o   (w_row),
    .sel_o   (w_sel),
    .last_o  (w_last)
  );

  assign in_ready_o   = ((state_q == PRIME) || (state_q == RUN)) && (!out_valid_q || out_ready_i);
  assign w_accept     = in_valid_i && in_ready_o;
  assign w_clear      = (state_q == IDLE) && start_i;
  assign w_handoff    = out_valid_q && out_ready_i;
  assign w_emit       = w_accept && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

  assign lb_wr_en_o   = w_accept;
  assign win_shift_o  = w_accept;
  assign lb_addr_o    = w_accept ? w_col : addr_q;
  assign lb_wr_sel_o  = w_sel;
  assign out_valid_o  = out_valid_q;
  assign out_row_o    = out_row_q;
  assign out_col_o    = out_col_q;
  assign kernel_sel_o = ksel_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = frame_done_q;

  always_comb begin
    state_d      = state_q;
    ksel_d       = ksel_q;
    out_valid_d  = out_valid_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    addr_d       = w_accept ? w_col : addr_q;
    frame_done_d = 1'b0;

    if (w_handoff) out_valid_d = 1'b0;
    // A fresh window overrides a simultaneous hand-off so valid stays high
    if (w_emit) begin
      out_valid_d = 1'b1;
      out_row_d   = w_row - ROW_W'(1);
      out_col_d   = w_col - COL_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = PRIME;
          ksel_d  = kernel_sel_t'(mode_i);
        end
      end
      PRIME: begin
        if (w_accept && (w_row == ROW_W'(2)) && (w_col == COL_W'(1))) state_d = RUN;
      end
      RUN: begin
        if (w_accept && w_last) state_d = DONE;
      end
      DONE: begin
        if (w_handoff) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ksel_q       <= KSEL_GAUSS;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ksel_q       <= ksel_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire
